tt_um_example_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 6 +
 rtl/up_counter.sv | 30 +++
 rtl/tt_um_example_counter.sv | 31 +++
 tb/tb_tt_um_example_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the Tiny Tapeout example counter tile.
package counter_pkg;
  localparam int          CNT_W     = 8;
  localparam int          LOAD_BIT  = 0;
  localparam logic [7:0]  RESET_VAL = 8'h00;
endpackage

// File: rtl/up_counter.sv
// Up-counter with enable and synchronous parallel load; reset beats enable beats load beats increment.
module up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    if (en) begin
      if (load) q_nxt = d;
      else      q_nxt = q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= WIDTH'(RESET_VAL);
    else        q <= q_nxt;
  end

endmodule

// File: rtl/tt_um_example_counter.sv
// Tiny Tapeout user tile: 8-bit counter on uo_out, load value on ui_in, load strobe on uio_in[0].
module tt_um_example_counter
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  up_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .load  (uio_in[LOAD_BIT]),
    .d     (ui_in),
    .q     (uo_out)
  );

  // The bidirectional bus is input-only here.
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_example_counter.sv
// Randomised and directed checks of the example counter tile against a byte-level reference model.
module tb_tt_um_example_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cnt = 8'h00;

  always #5 clk = ~clk;

  tt_um_example_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Advance one edge, apply the behavioural rules to the model, settle away from the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n)         exp_cnt = 8'h00;
    else if (!ena)      exp_cnt = exp_cnt;
    else if (uio_in[0]) exp_cnt = ui_in;
    else                exp_cnt = 8'((int'(exp_cnt) + 1) % 256);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    tick();
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_val: uo_out=%h exp=00", uo_out); end
    total++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      bad++; $display("FAIL reset_static: uio_out=%h uio_oe=%h exp=00/00", uio_out, uio_oe);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (uo_out !== 8'h01) begin bad++; $display("FAIL reset_first: uo_out=%h exp=01", uo_out); end
  endtask

  task automatic test_sweep();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 1; i <= 261; i++) begin
      tick();
      total++;
      if (uo_out !== exp_cnt || uo_out !== 8'(i % 256)) begin
        bad++; $display("FAIL sweep[%0d]: uo_out=%h exp=%h", i, uo_out, 8'(i % 256));
      end
    end
    total++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      bad++; $display("FAIL sweep_static: uio_out=%h uio_oe=%h exp=00/00", uio_out, uio_oe);
    end
  endtask

  task automatic test_load();
    ui_in = 8'h2B; uio_in = 8'hFF;
    tick();
    total++;
    if (uo_out !== 8'h2B) begin bad++; $display("FAIL load_take: uo_out=%h exp=2b", uo_out); end
    uio_in = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (uo_out !== 8'(8'h2B + i)) begin
        bad++; $display("FAIL load_inc[%0d]: uo_out=%h exp=%h", i, uo_out, 8'(8'h2B + i));
      end
    end
    // Strobe held: reload every edge.
    ui_in = 8'h77; uio_in = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (uo_out !== 8'h77) begin bad++; $display("FAIL load_hold[%0d]: uo_out=%h exp=77", i, uo_out); end
    end
    uio_in = 8'h00;
  endtask

  task automatic test_disable();
    logic [7:0] held;
    held = uo_out;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (uo_out !== held) begin bad++; $display("FAIL dis_hold[%0d]: uo_out=%h exp=%h", i, uo_out, held); end
    end
    ena = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (uo_out !== 8'(held + i)) begin
        bad++; $display("FAIL dis_resume[%0d]: uo_out=%h exp=%h", i, uo_out, 8'(held + i));
      end
    end
  endtask

  task automatic test_corners();
    logic [7:0] held;
    held = uo_out;
    ena = 1'b0; ui_in = ~held; uio_in = 8'h01;
    tick();
    total++;
    if (uo_out !== held) begin bad++; $display("FAIL load_no_ena: uo_out=%h exp=%h", uo_out, held); end
    ena = 1'b1; ui_in = 8'hFF;
    tick();
    uio_in = 8'h00;
    tick();
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL load_ff_wrap: uo_out=%h exp=00", uo_out); end
    tick(); tick();
    rst_n = 1'b0; ui_in = 8'h5A; uio_in = 8'h01;
    tick();
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL rst_with_load: uo_out=%h exp=00", uo_out); end
    rst_n = 1'b1; uio_in = 8'h00;
    tick();
    total++;
    if (uo_out !== 8'h01) begin bad++; $display("FAIL rst_load_rel: uo_out=%h exp=01", uo_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 31) != 0);
      ena    = ($urandom_range(0, 3) != 0);
      ui_in  = 8'($urandom);
      uio_in = {7'($urandom), ($urandom_range(0, 4) == 0)};
      tick();
      total++;
      if (uo_out !== exp_cnt || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        bad++;
        $display("FAIL random[%0d]: uo_out=%h exp=%h uio_out=%h uio_oe=%h", i, uo_out, exp_cnt, uio_out, uio_oe);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    #2;
    test_reset();
    test_sweep();
    test_load();
    test_disable();
    test_corners();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
